// File: rtl/ahb_arbiter.sv
// ahb_arbiter: central AHB bus arbiter with round-robin selection, locked
// transfers, defined-length burst tracking and SPLIT masking.
// Optional feature macro: AHB_ARB_SPLIT_EN
//   defined   -> a SPLIT response masks the data-phase master until HSPLIT
//   undefined -> SPLIT is treated exactly like RETRY, HSPLIT is ignored
module ahb_arbiter #(
    parameter  int NO_OF_MASTERS  = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = $clog2(NO_OF_MASTERS)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic                     HREADY,
    input  logic [1:0]               HRESP,
    input  logic [NO_OF_MASTERS-1:0] HSPLIT,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]            HMASTER,
    output logic                     HMASTLOCK
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWNED  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [1:0] RESP_RETRY = 2'd2;
    localparam logic [1:0] RESP_SPLIT = 2'd3;

    localparam logic [MW-1:0]            DEFAULT_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0] DEFAULT_GRANT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

    logic [1:0]               r_state;
    logic [NO_OF_MASTERS-1:0] r_grant;
    logic [MW-1:0]            r_ownerIdx;
    logic [MW-1:0]            r_hmaster;
    logic                     r_hmastlock;
    logic [MW-1:0]            r_dataMaster;
    logic [NO_OF_MASTERS-1:0] r_splitMask;
    logic [MW-1:0]            r_rrPtr;
    logic [4:0]               r_beatCnt;
    logic [4:0]               r_burstLen;
    logic                     r_forceArb;

    logic [NO_OF_MASTERS-1:0] w_eligible;
    logic                     w_ownerOnBus;
    logic [4:0]               w_beatLen;
    logic                     w_finalBeat;
    logic                     w_idleTrans;
    logic                     w_ownerDrop;
    logic                     w_arbCond;
    logic                     w_arbPoint;
    logic                     w_respFirst;
    logic                     w_found;
    logic [MW-1:0]            w_nextIdx;
    logic [NO_OF_MASTERS-1:0] w_nextGrant;
    int                       w_cand;
    logic [MW-1:0]            w_candIdx;

    assign w_eligible = HBUSREQ & ~r_splitMask;

    // HTRANS only describes the owner once its handover has reached the
    // address phase; before that, the previous master is still driving.
    assign w_ownerOnBus = (r_hmaster == r_ownerIdx);
    assign w_idleTrans  = w_ownerOnBus && (HTRANS == TR_IDLE);
    assign w_ownerDrop  = !HBUSREQ[r_ownerIdx];

    // First cycle of a two-cycle RETRY/SPLIT response
    assign w_respFirst = !HREADY && ((HRESP == RESP_RETRY) || (HRESP == RESP_SPLIT));

    // Burst length of the transfer on the bus; zero marks an unbounded INCR
    always_comb begin
        w_beatLen = 5'd0;
        case (HBURST)
            3'b000:        w_beatLen = 5'd1;
            3'b001:        w_beatLen = 5'd0;
            3'b010, 3'b011: w_beatLen = 5'd4;
            3'b100, 3'b101: w_beatLen = 5'd8;
            default:       w_beatLen = 5'd16;
        endcase
    end

    // The final beat of a defined-length burst is being accepted this cycle
    always_comb begin
        w_finalBeat = 1'b0;
        if (w_ownerOnBus) begin
            if (HTRANS == TR_NONSEQ)
                w_finalBeat = (w_beatLen == 5'd1);
            else if (HTRANS == TR_SEQ)
                w_finalBeat = (r_burstLen != 5'd0) && ((r_beatCnt + 5'd1) == r_burstLen);
        end
    end

    // Decide whether this cycle is an arbitration point; a locked owner
    // holds the bus until it releases HLOCK
    always_comb begin
        w_arbCond  = w_ownerDrop | w_idleTrans | w_finalBeat | r_forceArb;
        w_arbPoint = 1'b0;
        if (HREADY) begin
            case (r_state)
                ST_IDLE:   w_arbPoint = 1'b1;
                ST_LOCKED: w_arbPoint = !HLOCK[r_ownerIdx] && w_arbCond;
                default:   w_arbPoint = w_arbCond;
            endcase
        end
    end

    // Round-robin search over the eligible set starting after the pointer
    always_comb begin
        w_found   = 1'b0;
        w_nextIdx = DEFAULT_IDX;
        w_cand    = 0;
        w_candIdx = '0;
        for (int k = 1; k <= NO_OF_MASTERS; k++) begin
            w_cand    = (int'(r_rrPtr) + k) % NO_OF_MASTERS;
            w_candIdx = w_cand[MW-1:0];
            if (!w_found && w_eligible[w_candIdx]) begin
                w_found   = 1'b1;
                w_nextIdx = w_candIdx;
            end
        end
    end

    // One-hot form of the selected master
    always_comb begin
        w_nextGrant            = '0;
        w_nextGrant[w_nextIdx] = 1'b1;
    end

    // Grant, ownership state and round-robin pointer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant    <= DEFAULT_GRANT;
            r_ownerIdx <= DEFAULT_IDX;
            r_state    <= ST_IDLE;
            r_rrPtr    <= DEFAULT_IDX;
        end else if (w_arbPoint) begin
            r_grant    <= w_nextGrant;
            r_ownerIdx <= w_nextIdx;
            if (w_found) begin
                r_rrPtr <= w_nextIdx;
                r_state <= HLOCK[w_nextIdx] ? ST_LOCKED : ST_OWNED;
            end else begin
                r_state <= ST_IDLE;
            end
        end else if (w_respFirst) begin
            r_rrPtr <= r_dataMaster;
        end
    end

    // Address-phase and data-phase ownership advance only on HREADY
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hmaster    <= DEFAULT_IDX;
            r_hmastlock  <= 1'b0;
            r_dataMaster <= DEFAULT_IDX;
        end else if (HREADY) begin
            r_hmaster    <= r_ownerIdx;
            r_hmastlock  <= HLOCK[r_ownerIdx];
            r_dataMaster <= r_hmaster;
        end
    end

    // Beat counter: NONSEQ starts a burst, SEQ counts further beats
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_beatCnt  <= 5'd0;
            r_burstLen <= 5'd0;
        end else if (HREADY) begin
            if (HTRANS == TR_NONSEQ) begin
                r_beatCnt  <= 5'd1;
                r_burstLen <= w_beatLen;
            end else if ((HTRANS == TR_SEQ) && (r_beatCnt != 5'h1f)) begin
                r_beatCnt <= r_beatCnt + 5'd1;
            end
        end
    end

    // Remember a RETRY/SPLIT first cycle so the completing cycle re-arbitrates
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_forceArb <= 1'b0;
        else if (w_respFirst)
            r_forceArb <= 1'b1;
        else if (HREADY)
            r_forceArb <= 1'b0;
    end

`ifdef AHB_ARB_SPLIT_EN
    logic [NO_OF_MASTERS-1:0] w_splitSet;

    // Bit to mask when the data-phase master is being split
    always_comb begin
        w_splitSet = '0;
        if (!HREADY && (HRESP == RESP_SPLIT))
            w_splitSet[r_dataMaster] = 1'b1;
    end

    // Split mask: release by HSPLIT first, then set, so a set wins a tie
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_splitMask <= '0;
        else
            r_splitMask <= (r_splitMask & ~HSPLIT) | w_splitSet;
    end
`else
    logic w_unusedSplit;
    assign w_unusedSplit = ^HSPLIT;

    // Without split masking nobody is ever excluded from arbitration
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_splitMask <= '0;
        else
            r_splitMask <= '0;
    end
`endif

    assign HGRANT    = r_grant;
    assign HMASTER   = r_hmaster;
    assign HMASTLOCK = r_hmastlock;

endmodule
